input_ctrl: RTL and testbench

Keyboard-to-game input stage sitting directly upstream of `player`. It samples the two USB HID keycode bytes once per frame and resolves left/right into a single direction using last-pressed-wins. It turns the fire key into rate-limited one-frame fire requests. All outputs are registered and change only on a frame tick, so `player` and the bullet logic see stable per-frame commands.

---
 rtl/game_pkg.sv | 9 +
 rtl/frame_edge_detect.sv | 22 ++
 rtl/input_ctrl.sv | 96 +++++++++
 tb/tb_input_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the game input/player/bullet blocks.
package game_pkg;
    localparam logic [7:0] KC_LEFT  = 8'd80;
    localparam logic [7:0] KC_RIGHT = 8'd79;
    localparam logic [7:0] KC_FIRE  = 8'd44;
    localparam int         CD_W     = 6;

    typedef enum logic [1:0] {DIR_IDLE, DIR_LEFT, DIR_RIGHT} dir_t;
endpackage

// File: rtl/frame_edge_detect.sv
// Registered rising-edge pulse of the vsync-rate frame strobe.
module frame_edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick_o
);
    logic frame_clk_q;
    logic tick_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
            tick_q      <= frame_clk & ~frame_clk_q;
        end
    end

    assign tick_o = tick_q;
endmodule

// File: rtl/input_ctrl.sv
// Per-frame keyboard decode: last-pressed-wins direction and rate-limited fire.
// Define INPUT_CTRL_AUTOFIRE_EN to let a held fire key re-fire when the cooldown expires.
module input_ctrl
    import game_pkg::*;
#(
    parameter logic [7:0]      KEY_LEFT      = KC_LEFT,
    parameter logic [7:0]      KEY_RIGHT     = KC_RIGHT,
    parameter logic [7:0]      KEY_FIRE      = KC_FIRE,
    parameter logic [CD_W-1:0] FIRE_COOLDOWN = 6'd15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic       move_left,
    output logic       move_right,
    output logic       fire,
    output logic       frame_tick
);
    logic tick;

    frame_edge_detect u_edge (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .tick_o   (tick)
    );

    dir_t            state_q, state_d;
    logic            left_prev_q, right_prev_q, fire_prev_q;
    logic [CD_W-1:0] cd_q, cd_d;
    logic            fire_q, fire_d;
    logic            frame_tick_q;

    logic left_held, right_held, fire_held, armed;

    assign left_held  = (keycode0 == KEY_LEFT)  || (keycode1 == KEY_LEFT);
    assign right_held = (keycode0 == KEY_RIGHT) || (keycode1 == KEY_RIGHT);
    assign fire_held  = (keycode0 == KEY_FIRE)  || (keycode1 == KEY_FIRE);

`ifdef INPUT_CTRL_AUTOFIRE_EN
    assign armed = fire_held && (cd_q == '0);
`else
    assign armed = fire_held && (cd_q == '0) && !fire_prev_q;
`endif

    always_comb begin
        state_d = state_q;
        if (left_held && right_held) begin
            // Newest press wins; a simultaneous press is ambiguous, so stop.
            if (!left_prev_q && !right_prev_q) state_d = DIR_IDLE;
            else if (!right_prev_q)            state_d = DIR_RIGHT;
            else if (!left_prev_q)             state_d = DIR_LEFT;
        end else if (left_held) begin
            state_d = DIR_LEFT;
        end else if (right_held) begin
            state_d = DIR_RIGHT;
        end else begin
            state_d = DIR_IDLE;
        end
    end

    always_comb begin
        fire_d = armed;
        cd_d   = (cd_q != '0) ? cd_q - 1'b1 : cd_q;
        if (armed) cd_d = FIRE_COOLDOWN;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= DIR_IDLE;
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
            fire_prev_q  <= 1'b0;
            cd_q         <= '0;
            fire_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= tick;
            if (tick) begin
                state_q      <= state_d;
                left_prev_q  <= left_held;
                right_prev_q <= right_held;
                fire_prev_q  <= fire_held;
                cd_q         <= cd_d;
                fire_q       <= fire_d;
            end
        end
    end

    assign move_left  = (state_q == DIR_LEFT);
    assign move_right = (state_q == DIR_RIGHT);
    assign fire       = fire_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_input_ctrl.sv
module tb_input_ctrl;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode0 = 8'd0;
    logic [7:0] keycode1 = 8'd0;
    logic       move_left, move_right, fire, frame_tick;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    input_ctrl #(.FIRE_COOLDOWN(6'd3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode0  (keycode0),
        .keycode1  (keycode1),
        .move_left (move_left),
        .move_right(move_right),
        .fire      (fire),
        .frame_tick(frame_tick)
    );

    typedef struct {
        logic [7:0] k0;
        logic [7:0] k1;
        logic       l;
        logic       r;
        logic       f;
    } vec_t;

    localparam int N = 36;
    vec_t tbl[N];

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int idx, input logic l, input logic r, input logic f);
        chk({name, ".left"},  idx, move_left,  l);
        chk({name, ".right"}, idx, move_right, r);
        chk({name, ".fire"},  idx, fire,       f);
    endtask

    // One frame: frame_clk high for 2 cycles starting at a negedge.
    // Returns after the update edge + #1, with frame_tick expected high.
    task automatic frame_rise(input int idx, input logic l_old, input logic r_old, input logic f_old);
        @(negedge Clk);
        frame_clk = 1'b1;
        @(posedge Clk); #1;
        chk("tick_early", idx, frame_tick, 1'b0);
        chk_out("hold_pre", idx, l_old, r_old, f_old);
        @(posedge Clk); #1;
        chk("tick", idx, frame_tick, 1'b1);
    endtask

    task automatic frame_tail(input int idx, input logic l, input logic r, input logic f);
        @(negedge Clk);
        frame_clk = 1'b0;
        @(posedge Clk); #1;
        chk("tick_low", idx, frame_tick, 1'b0);
        chk_out("hold_post", idx, l, r, f);
        repeat (3) @(posedge Clk);
    endtask

    function automatic vec_t v(input logic [7:0] k0, input logic [7:0] k1,
                               input logic l, input logic r, input logic f);
        vec_t t;
        t.k0 = k0; t.k1 = k1; t.l = l; t.r = r; t.f = f;
        return t;
    endfunction

    logic pl, pr, pf;

    initial begin
        int n = 0;
        // idle frames
        for (int i = 0; i < 3; i++) tbl[n++] = v(0, 0, 0, 0, 0);
        // direction: left, left, right added wins, release right -> left
        tbl[n++] = v(80, 0, 1, 0, 0);
        tbl[n++] = v(80, 0, 1, 0, 0);
        tbl[n++] = v(80, 79, 0, 1, 0);
        tbl[n++] = v(80, 0, 1, 0, 0);
        tbl[n++] = v(0, 0, 0, 0, 0);
        // simultaneous press from idle -> idle; drop left -> right
        tbl[n++] = v(80, 79, 0, 0, 0);
        tbl[n++] = v(0, 79, 0, 1, 0);
        tbl[n++] = v(0, 0, 0, 0, 0);
        // fire, release, press during cooldown dropped, release, press fires
        tbl[n++] = v(44, 0, 0, 0, 1);
        tbl[n++] = v(0, 0, 0, 0, 0);
        tbl[n++] = v(0, 44, 0, 0, 0);
        tbl[n++] = v(0, 0, 0, 0, 0);
        tbl[n++] = v(44, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) tbl[n++] = v(0, 0, 0, 0, 0);
        // hold fire (duplicate in both slots) for 10 ticks
        for (int i = 1; i <= 10; i++) begin
`ifdef INPUT_CTRL_AUTOFIRE_EN
            tbl[n++] = v(44, 44, 0, 0, (i == 1 || i == 5 || i == 9));
`else
            tbl[n++] = v(44, 44, 0, 0, (i == 1));
`endif
        end
        tbl[n++] = v(0, 0, 0, 0, 0);
        // unrelated codes ignored; left with junk in other slot
        tbl[n++] = v(5, 9, 0, 0, 0);
        tbl[n++] = v(80, 5, 1, 0, 0);
        for (int i = 0; i < 4; i++) tbl[n++] = v(0, 0, 0, 0, 0);

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst_tick", 0, frame_tick, 1'b0);
        chk_out("rst", 0, 0, 0, 0);

        pl = 0; pr = 0; pf = 0;
        for (int i = 0; i < N; i++) begin
            @(negedge Clk);
            keycode0 = tbl[i].k0;
            keycode1 = tbl[i].k1;
            frame_rise(i, pl, pr, pf);
            chk_out("vec", i, tbl[i].l, tbl[i].r, tbl[i].f);
            frame_tail(i, tbl[i].l, tbl[i].r, tbl[i].f);
            pl = tbl[i].l; pr = tbl[i].r; pf = tbl[i].f;
        end

        // Key pressed only between ticks is never seen.
        @(negedge Clk);
        keycode0 = 8'd80;
        repeat (3) @(negedge Clk);
        keycode0 = 8'd0;
        frame_rise(100, 0, 0, 0);
        chk_out("between", 100, 0, 0, 0);
        frame_tail(100, 0, 0, 0);

        // Left + fire, then reset mid-cooldown with both still held.
        @(negedge Clk);
        keycode0 = 8'd80;
        keycode1 = 8'd44;
        frame_rise(101, 0, 0, 0);
        chk_out("pre_rst", 101, 1, 0, 1);
        frame_tail(101, 1, 0, 1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk_out("mid_rst", 102, 0, 0, 0);
        chk("mid_rst_tick", 102, frame_tick, 1'b0);
        // Prev flags and cooldown cleared: fire and left re-trigger at once.
        frame_rise(103, 0, 0, 0);
        chk_out("post_rst", 103, 1, 0, 1);
        frame_tail(103, 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
